// File: rtl/pc_stack_if.sv
// Control/status bundle between the control-unit FSM (master) and the program
// counter with call/return stack (slave).
interface pc_stack_if #(
  parameter int AW    = 7,
  parameter int OFFW  = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic            up;
  logic            ld;
  logic            br;
  logic            call;
  logic            ret;
  logic [AW-1:0]   target;
  logic [OFFW-1:0] off;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   depth;
  logic            empty;
  logic            full;
  logic            ovf;
  logic            unf;

  modport master (
    output up, ld, br, call, ret, target, off,
    input  mem_addr, depth, empty, full, ovf, unf
  );

  modport slave (
    input  up, ld, br, call, ret, target, off,
    output mem_addr, depth, empty, full, ovf, unf
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with absolute jump, signed relative branch and a LIFO
// return-address stack; one action per cycle, priority Call > Ret > Ld > Br > Up.
module pc_stack #(
  parameter int AW    = 7,
  parameter int OFFW  = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = (AW > OFFW) ? AW : OFFW;

  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q,   ovf_d;
  logic          unf_q,   unf_d;
  logic [AW-1:0] stack_q [2**IW];

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic [AW-1:0] next_addr_s;
  logic [AW-1:0] br_addr_s;
  logic [EW-1:0] br_sum_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;

  assign empty_s     = (depth_q == {DW{1'b0}});
  assign full_s      = (depth_q == DW'(DEPTH));
  assign next_addr_s = addr_q + AW'(1);
  assign wr_idx_s    = IW'(depth_q);
  assign rd_idx_s    = IW'(depth_q - DW'(1));

  // Branch offset is sign-extended to the wider of the two widths before the add.
  assign br_sum_s  = EW'(addr_q) + EW'($signed(bus.off));
  assign br_addr_s = br_sum_s[AW-1:0];

  // Next-state selection by fixed action priority.
  always_comb begin
    addr_d  = addr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_s  = 1'b0;
    if (bus.call) begin
      if (full_s) begin
        ovf_d = 1'b1;
      end else begin
        push_s  = 1'b1;
        depth_d = depth_q + DW'(1);
        addr_d  = bus.target;
      end
    end else if (bus.ret) begin
      if (empty_s) begin
        unf_d = 1'b1;
      end else begin
        addr_d  = stack_q[rd_idx_s];
        depth_d = depth_q - DW'(1);
      end
    end else if (bus.ld) begin
      addr_d = bus.target;
    end else if (bus.br) begin
      addr_d = br_addr_s;
    end else if (bus.up) begin
      addr_d = next_addr_s;
    end else begin
      addr_d = addr_q;
    end
  end

  // Architectural state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= {AW{1'b0}};
      depth_q <= {DW{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset: entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[wr_idx_s] <= next_addr_s;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.depth    = depth_q;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with absolute jump, signed relative branch and a hardware call/return stack. It generates the instruction-memory address for the processor datapath and is driven cycle by cycle by the control-unit FSM. It generalises the plain up-counter PC with configurable address width, configurable stack depth and sticky fault flags for stack misuse.

## Interface
- AW, default 7: address width in bits; mem_addr wraps modulo 2^AW.
- OFFW, default 8: width of the signed branch offset.
- DEPTH, default 4: number of return-address stack entries (at least 1).
- Clk  input  1  single clock; all state updates on the rising edge.
- Clr  input  1  reset, asynchronous, active-high; clears all state.
- Up  input  1  increment enable.
- Ld  input  1  absolute jump: mem_addr <= Target.
- Br  input  1  relative branch: mem_addr <= mem_addr + sext(Off).
- Call  input  1  push mem_addr+1 and jump to Target.
- Ret  input  1  pop the return address into mem_addr.
- Target  input  AW  jump/call destination.
- Off  input  OFFW  two's-complement branch offset.
- mem_addr  output  AW  current instruction address (registered).
- Depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- Empty  output  1  Depth == 0 (combinational from Depth).
- Full  output  1  Depth == DEPTH (combinational from Depth).
- Ovf  output  1  sticky: a Call was attempted while Full.
- Unf  output  1  sticky: a Ret was attempted while Empty.

## Operation
- Reset (Clr=1, asynchronous): mem_addr=0, Depth=0, Ovf=0, Unf=0, stack contents don't-care. Empty=1, Full=0.
- Each cycle exactly one action executes, chosen by fixed priority Call > Ret > Ld > Br > Up > hold. Lower-priority requests in the same cycle are ignored (not queued).
- Up: mem_addr <= mem_addr + 1, modulo 2^AW (127 -> 0 at AW=7).
- Ld: mem_addr <= Target.
- Br: sign-extend Off to the larger of AW and OFFW, add it to the current mem_addr (not mem_addr+1), then truncate to AW bits. Wraps in both directions.
- Call, not Full: stack[Depth] <= (mem_addr+1) mod 2^AW; Depth <= Depth+1; mem_addr <= Target.
- Call, Full: no push, mem_addr unchanged, Depth unchanged; Ovf <= 1.
- Ret, not Empty: mem_addr <= stack[Depth-1]; Depth <= Depth-1.
- Ret, Empty: mem_addr and Depth unchanged; Unf <= 1.
- Ovf and Unf clear only on Clr.
- Stack is LIFO. Entries at or above Depth are never read.

## Timing
- All outputs are registered except Empty and Full, which decode from the registered Depth. There is no combinational path from inputs to outputs.
- Latency: an action sampled at edge N is visible on mem_addr, Depth and the flags immediately after edge N.
- Back-to-back Call/Ret on consecutive cycles is supported at full rate. No bubbles are required.
- Clr asserted mid-operation, including between a Call and its Ret, discards all pending state at once. The first action after deassertion starts from mem_addr=0 with an empty stack.
- Clr deassertion is synchronised externally by the FSM. The block assumes Clr releases away from the rising edge of Clk.

## Test plan
All scenarios use AW=7, OFFW=8, DEPTH=4.
- Reset then Up=1 for 20 cycles -> mem_addr=20, Depth=0, Empty=1. Then Up=0 for 10 cycles -> mem_addr holds at 20. Then assert Clr asynchronously between edges -> mem_addr=0 before the next edge.
- Ld Target=125, then Up for 5 cycles -> 126, 127, 0, 1, 2 (wrap). Next, Br with Off=-4 (0xFC) at mem_addr=2 -> 126. Br with Off=+10 at mem_addr=126 -> 8.
- At mem_addr=10: Call Target=40 -> mem_addr=40, Depth=1. Up x3 -> 43. Call Target=90 -> 90, Depth=2. Ret -> 44. Ret -> 11, Depth=0, Empty=1.
- Four nested Calls -> Full=1, Depth=4. A fifth Call with Target=5 -> mem_addr unchanged, Depth=4, Ovf=1. Four Rets then return the pushed addresses in reverse order. A fifth Ret -> Unf=1 with mem_addr unchanged. Both flags stay 1 until Clr.
- Simultaneous Call+Ret+Ld+Up at mem_addr=7 with Target=60 -> Call wins: mem_addr=60, stack top=8. Simultaneous Ld+Br+Up with Target=3 -> mem_addr=3.
- Call at mem_addr=127 -> pushed return address is 0. Ret later restores 0.
